variance_cache_ctrl: RTL and testbench

- Sequencer for the 4-entry variance cache, which holds integral-image (area) and squared-integral (areaSq) corner values.
- Accepts the 4 corner samples of one detection window and writes each into the cache.
- Reads the 4 corners back, accumulates the signed corner combination c0 - c1 - c2 + c3 for both sum and sum-of-squares, and presents the result on a valid/ready output.
- Sits between the integral-image fetch stage and the variance-threshold stage of the classifier pipeline.

---
 rtl/variance_cache_ctrl_pkg.sv | 21 ++
 rtl/variance_norm_calc.sv | 23 ++
 rtl/variance_cache_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_variance_cache_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/variance_cache_ctrl_pkg.sv
// Shared defaults, FSM state type and corner sign pattern for the variance cache sequencer.
package variance_cache_ctrl_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 2;
   localparam int unsigned DEF_WORD_SIZE    = 32;
   localparam int unsigned DEF_WORD_SIZE_SQ = 48;
   localparam int unsigned DEF_WIN_AREA     = 400;
   localparam int unsigned DEF_NORM_W       = 96;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StAcc,
      StNorm,
      StOut
   } vc_state_e;

   // Bit k set means corner k is added, clear means subtracted: c0 - c1 - c2 + c3.
   localparam logic [3:0] CORNER_SIGN = 4'b1001;

endpackage

// File: rtl/variance_norm_calc.sv
// Normalised variance term N*sqsum - sum^2, truncated to NORM_W and read as signed.
// Instantiated only when VARIANCE_CACHE_CTRL_NORM_EN is defined.
module variance_norm_calc #(
   parameter int unsigned WORD_SIZE    = 32,
   parameter int unsigned WORD_SIZE_SQ = 48,
   parameter int unsigned WIN_AREA     = 400,
   parameter int unsigned NORM_W       = 96
) (
   input  logic [WORD_SIZE-1:0]    sum,
   input  logic [WORD_SIZE_SQ-1:0] sqsum,
   output logic [NORM_W-1:0]       norm
);

   localparam logic [NORM_W-1:0] AREA = NORM_W'(WIN_AREA);

   logic [NORM_W-1:0] sum_ext;
   logic [NORM_W-1:0] sqsum_ext;

   assign sum_ext   = NORM_W'(sum);
   assign sqsum_ext = NORM_W'(sqsum);
   assign norm      = (AREA * sqsum_ext) - (sum_ext * sum_ext);

endmodule

// File: rtl/variance_cache_ctrl.sv
// Variance cache sequencer: loads four window corners into the cache, reads them back and
// accumulates c0 - c1 - c2 + c3. Define VARIANCE_CACHE_CTRL_NORM_EN to add the out_norm stage.
module variance_cache_ctrl
   import variance_cache_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
   parameter int unsigned WORD_SIZE_SQ = DEF_WORD_SIZE_SQ
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   ,
   parameter int unsigned WIN_AREA     = DEF_WIN_AREA,
   parameter int unsigned NORM_W       = DEF_NORM_W
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_SIZE-1:0]    in_ii,
   input  logic [WORD_SIZE_SQ-1:0] in_sqii,
   output logic                    vc_we,
   output logic [ADDR_WIDTH-1:0]   vc_waddr,
   output logic [WORD_SIZE-1:0]    vc_wdata,
   output logic                    vc_weSQ,
   output logic [ADDR_WIDTH-1:0]   vc_waddrSQ,
   output logic [WORD_SIZE_SQ-1:0] vc_wdataSQ,
   output logic [ADDR_WIDTH-1:0]   vc_raddr,
   output logic [ADDR_WIDTH-1:0]   vc_raddrSQ,
   input  logic [WORD_SIZE-1:0]    vc_q,
   input  logic [WORD_SIZE_SQ-1:0] vc_qSQ,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_SIZE-1:0]    out_sum,
   output logic [WORD_SIZE_SQ-1:0] out_sqsum
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   ,
   output logic [NORM_W-1:0]       out_norm
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_CORNER = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);

   vc_state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]     corner_q, corner_d;
   logic [ADDR_WIDTH-1:0]     rd_q, rd_d;
   logic [WORD_SIZE-1:0]      sum_q, sum_d;
   logic [WORD_SIZE_SQ-1:0]   sqsum_q, sqsum_d;

   logic                      in_fire;
   logic                      out_fire;
   logic                      acc_en;
   logic [ADDR_WIDTH-1:0]     acc_idx;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Cache write port follows the input handshake directly.
   assign vc_we      = in_fire;
   assign vc_weSQ    = in_fire;
   assign vc_waddr   = corner_q;
   assign vc_waddrSQ = corner_q;
   assign vc_wdata   = in_ii;
   assign vc_wdataSQ = in_sqii;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_fire && (corner_q == LAST_CORNER)) begin
               state_d = StRead;
            end
         end
         StRead: begin
            if (rd_q == LAST_CORNER) begin
               state_d = StAcc;
            end
         end
         StAcc: begin
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
            state_d = StNorm;
`else
            state_d = StOut;
`endif
         end
         StNorm: state_d = StOut;
         StOut: begin
            if (out_fire) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode. Read data lags the issued address by one cycle, so the corner being
   // accumulated is the previous rd count, and corner 3 lands in StAcc.
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      vc_raddr   = '0;
      vc_raddrSQ = '0;
      acc_en     = 1'b0;
      acc_idx    = '0;
      unique case (state_q)
         StIdle: in_ready = ~rst;
         StRead: begin
            vc_raddr   = rd_q;
            vc_raddrSQ = rd_q;
            acc_en     = (rd_q != '0);
            acc_idx    = rd_q - ADDR_ONE;
         end
         StAcc: begin
            acc_en  = 1'b1;
            acc_idx = LAST_CORNER;
         end
         StNorm: ;
         StOut: out_valid = 1'b1;
         default: ;
      endcase
   end

   // Corner and read counters.
   always_comb begin
      corner_d = corner_q;
      rd_d     = '0;
      if (in_fire) begin
         corner_d = (corner_q == LAST_CORNER) ? '0 : corner_q + ADDR_ONE;
      end
      if (state_q == StRead) begin
         rd_d = rd_q + ADDR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         corner_q <= '0;
         rd_q     <= '0;
      end else begin
         corner_q <= corner_d;
         rd_q     <= rd_d;
      end
   end

   // Accumulators clear when a new window starts and wrap modulo their widths.
   always_comb begin
      sum_d   = sum_q;
      sqsum_d = sqsum_q;
      if (in_fire && (corner_q == '0)) begin
         sum_d   = '0;
         sqsum_d = '0;
      end else if (acc_en) begin
         if (CORNER_SIGN[acc_idx]) begin
            sum_d   = sum_q + vc_q;
            sqsum_d = sqsum_q + vc_qSQ;
         end else begin
            sum_d   = sum_q - vc_q;
            sqsum_d = sqsum_q - vc_qSQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         sqsum_q <= '0;
      end else begin
         sum_q   <= sum_d;
         sqsum_q <= sqsum_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_sqsum = sqsum_q;

`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   logic [NORM_W-1:0] norm_d;
   logic [NORM_W-1:0] norm_q;

   variance_norm_calc #(
      .WORD_SIZE    (WORD_SIZE),
      .WORD_SIZE_SQ (WORD_SIZE_SQ),
      .WIN_AREA     (WIN_AREA),
      .NORM_W       (NORM_W)
   ) u_norm_calc (
      .sum   (sum_q),
      .sqsum (sqsum_q),
      .norm  (norm_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         norm_q <= '0;
      end else if (state_q == StNorm) begin
         norm_q <= norm_d;
      end
   end

   assign out_norm = norm_q;
`endif

endmodule

// File: tb/tb_variance_cache_ctrl.sv
// Self-checking bench for variance_cache_ctrl: table vectors, corner-case sequences and
// randomized windows against a corner-combination reference model.
module tb_variance_cache_ctrl;

   localparam int unsigned AW  = 2;
   localparam int unsigned WS  = 32;
   localparam int unsigned WSQ = 48;
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   localparam int unsigned TB_WIN_AREA = 4;
   localparam int unsigned TB_NORM_W   = 96;
   localparam int EXP_LAT = 7;
`else
   localparam int EXP_LAT = 6;
`endif

   typedef struct packed {
      logic [3:0][WS-1:0]  ii;
      logic [3:0][WSQ-1:0] sq;
      logic [7:0]          gap_at;
      logic [7:0]          gap_len;
      logic [7:0]          hold;
      logic [WS-1:0]       exp_sum;
      logic [WSQ-1:0]      exp_sq;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [WS-1:0]  in_ii;
   logic [WSQ-1:0] in_sqii;
   logic           vc_we, vc_weSQ;
   logic [AW-1:0]  vc_waddr, vc_waddrSQ, vc_raddr, vc_raddrSQ;
   logic [WS-1:0]  vc_wdata;
   logic [WSQ-1:0] vc_wdataSQ;
   logic [WS-1:0]  vc_q;
   logic [WSQ-1:0] vc_qSQ;
   logic           out_valid;
   logic           out_ready;
   logic [WS-1:0]  out_sum;
   logic [WSQ-1:0] out_sqsum;
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   logic [TB_NORM_W-1:0] out_norm;
`endif

   int errors = 0;
   int checks = 0;

   logic [WS-1:0]  mem_a  [4];
   logic [WSQ-1:0] mem_sq [4];
   logic [AW-1:0]  log_addr[$];
   logic [WS-1:0]  log_data[$];
   logic [WSQ-1:0] log_sq[$];

   always #5 clk = ~clk;

   variance_cache_ctrl #(
      .ADDR_WIDTH   (AW),
      .WORD_SIZE    (WS),
      .WORD_SIZE_SQ (WSQ)
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
      ,
      .WIN_AREA     (TB_WIN_AREA),
      .NORM_W       (TB_NORM_W)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ii      (in_ii),
      .in_sqii    (in_sqii),
      .vc_we      (vc_we),
      .vc_waddr   (vc_waddr),
      .vc_wdata   (vc_wdata),
      .vc_weSQ    (vc_weSQ),
      .vc_waddrSQ (vc_waddrSQ),
      .vc_wdataSQ (vc_wdataSQ),
      .vc_raddr   (vc_raddr),
      .vc_raddrSQ (vc_raddrSQ),
      .vc_q       (vc_q),
      .vc_qSQ     (vc_qSQ),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_sqsum  (out_sqsum)
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
      ,
      .out_norm   (out_norm)
`endif
   );

   // Cache model: synchronous write, one-cycle read latency.
   initial begin
      for (int i = 0; i < 4; i++) begin
         mem_a[i]  = '0;
         mem_sq[i] = '0;
      end
   end

   always @(posedge clk) begin
      if (vc_we) mem_a[vc_waddr] <= vc_wdata;
      if (vc_weSQ) mem_sq[vc_waddrSQ] <= vc_wdataSQ;
      vc_q   <= mem_a[vc_raddr];
      vc_qSQ <= mem_sq[vc_raddrSQ];
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Write monitor: both cache ports must pulse together at the same address.
   always @(negedge clk) begin
      if (vc_we || vc_weSQ) begin
         check("we pair", 128'({vc_weSQ, vc_waddrSQ}), 128'({vc_we, vc_waddr}));
         log_addr.push_back(vc_waddr);
         log_data.push_back(vc_wdata);
         log_sq.push_back(vc_wdataSQ);
      end
   end

   function automatic logic [WS-1:0] model_sum(input vec_t v);
      return v.ii[0] - v.ii[1] - v.ii[2] + v.ii[3];
   endfunction

   function automatic logic [WSQ-1:0] model_sq(input vec_t v);
      return v.sq[0] - v.sq[1] - v.sq[2] + v.sq[3];
   endfunction

`ifdef VARIANCE_CACHE_CTRL_NORM_EN
   function automatic logic [TB_NORM_W-1:0] norm_ref(input logic [WS-1:0] s,
                                                      input logic [WSQ-1:0] q);
      logic [TB_NORM_W-1:0] n, se, qe;
      n  = TB_NORM_W'(TB_WIN_AREA);
      se = TB_NORM_W'(s);
      qe = TB_NORM_W'(q);
      return n * qe - se * se;
   endfunction
`endif

   function automatic vec_t mk(input logic [WS-1:0] a0, a1, a2, a3,
                               input logic [WSQ-1:0] s0, s1, s2, s3,
                               input int gap_at, gap_len, hold,
                               input logic [WS-1:0] es, input logic [WSQ-1:0] eq);
      vec_t v;
      v.ii[0] = a0; v.ii[1] = a1; v.ii[2] = a2; v.ii[3] = a3;
      v.sq[0] = s0; v.sq[1] = s1; v.sq[2] = s2; v.sq[3] = s3;
      v.gap_at  = 8'(gap_at);
      v.gap_len = 8'(gap_len);
      v.hold    = 8'(hold);
      v.exp_sum = es;
      v.exp_sq  = eq;
      return v;
   endfunction

   // Entered and left just after a rising edge.
   task automatic send_corner(input string name, input logic [WS-1:0] a, input logic [WSQ-1:0] s);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_ii    = a;
      in_sqii  = s;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 20);
      check({name, " in_ready"}, 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_window(input vec_t v, input string name);
      int lat;
      int base;
      base = log_addr.size();
      out_ready = (v.hold == 0);
      for (int c = 0; c < 4; c++) begin
         if (c == int'(v.gap_at) && v.gap_len != 0) begin
            in_valid = 1'b0;
            repeat (int'(v.gap_len)) @(posedge clk);
            #1;
         end
         send_corner(name, v.ii[c], v.sq[c]);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check({name, " latency"}, 128'(lat), 128'(EXP_LAT));
      check({name, " sum"}, 128'(out_sum), 128'(v.exp_sum));
      check({name, " sqsum"}, 128'(out_sqsum), 128'(v.exp_sq));
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
      check({name, " norm"}, 128'(out_norm), 128'(norm_ref(v.exp_sum, v.exp_sq)));
`endif
      if (v.hold != 0) begin
         for (int h = 0; h < int'(v.hold); h++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            @(negedge clk);
            check({name, " hold valid/ready/we"}, 128'({out_valid, in_ready, vc_we}),
                  128'(3'b100));
            check({name, " hold data"}, 128'({out_sum, out_sqsum}),
                  128'({v.exp_sum, v.exp_sq}));
         end
         @(posedge clk);
         #1;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         check({name, " valid before accept"}, 128'(out_valid), 128'(1));
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      check({name, " valid drop/idle"}, 128'({out_valid, in_ready}), 128'(2'b01));
      check({name, " write count"}, 128'(log_addr.size() - base), 128'(4));
      for (int k = 0; k < 4 && base + k < log_addr.size(); k++) begin
         check({name, " write entry"}, 128'({log_addr[base + k], log_data[base + k],
                                            log_sq[base + k]}),
               128'({AW'(k), v.ii[k], v.sq[k]}));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t tbl[5];
      vec_t rv;
      logic [63:0] r64;
      int hi;

      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      vec_t rv;
      logic [63:0] r64;
      int hi;

      tbl[0] = mk(100, 30, 20, 5, 1000, 300, 200, 50, 255, 0, 0, 55, 550);
      tbl[1] = mk(100, 30, 20, 5, 1000, 300, 200, 50, 2, 3, 0, 55, 550);
      tbl[2] = mk(100, 30, 20, 5, 1000, 300, 200, 50, 255, 0, 5, 55, 550);
      tbl[3] = mk(0, 1, 0, 0, 0, 0, 0, 0, 255, 0, 0, 32'hFFFF_FFFF, 0);
      tbl[4] = mk(6, 0, 0, 0, 10, 0, 0, 0, 255, 0, 0, 6, 10);

      // Reset state, with in_valid high to show reset masks the handshake.
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_ii = 32'd99; in_sqii = 48'd99;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready/we/valid", 128'({in_ready, vc_we, out_valid}), 128'(0));
      check("reset sums", 128'({out_sum, out_sqsum}), 128'(0));
      check("reset raddr", 128'({vc_raddr, vc_raddrSQ}), 128'(0));
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
      check("reset norm", 128'(out_norm), 128'(0));
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("idle ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) begin
         run_window(tbl[i], $sformatf("vec%0d", i));
      end
`ifdef VARIANCE_CACHE_CTRL_NORM_EN
      check("norm N=4 sum=6 sq=10", 128'(out_norm), 128'(4));
`endif

      // Reset after two corners; the partial window must vanish.
      send_corner("partial", 32'd77, 48'd700);
      send_corner("partial", 32'd88, 48'd800);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post-reset state", 128'({in_ready, out_valid, out_sum}), 128'({1'b1, 1'b0, 32'd0}));
      @(posedge clk);
      #1;
      run_window(mk(10, 4, 3, 1, 9, 5, 2, 1, 255, 0, 0, 4, 3), "after reset");

      // Reset during READ: no result may appear.
      for (int c = 0; c < 4; c++) send_corner("abort", 32'(c + 1), 48'(c + 1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hi = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (out_valid) hi++;
      end
      check("abort no output", 128'(hi), 128'(0));
      check("abort idle sum", 128'({in_ready, out_sum}), 128'({1'b1, 32'd0}));
      @(posedge clk);
      #1;

      // Randomized windows against the reference model.
      for (int i = 0; i < 30; i++) begin
         for (int c = 0; c < 4; c++) begin
            rv.ii[c] = (i % 5 == 0) ? WS'($urandom_range(3)) : WS'($urandom);
            r64 = {$urandom, $urandom};
            rv.sq[c] = r64[WSQ-1:0];
         end
         rv.gap_at  = 8'($urandom_range(3));
         rv.gap_len = 8'($urandom_range(3));
         rv.hold    = 8'($urandom_range(3));
         rv.exp_sum = model_sum(rv);
         rv.exp_sq  = model_sq(rv);
         run_window(rv, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
